// File: rtl/noc_pkg.sv
// Shared widths, flit layout, link handshake levels and output FSM states for the mesh link buffer.
package noc_pkg;

  localparam int unsigned NOC_ADDR_W = 5;
  localparam int unsigned NOC_DATA_W = 32;
  localparam int unsigned NOC_DEPTH  = 4;

  typedef struct packed {
    logic [NOC_ADDR_W-1:0] addr;
    logic [NOC_DATA_W-1:0] data;
  } flit_t;

  localparam logic LINK_ACK  = 1'b1;
  localparam logic LINK_IDLE = 1'b0;

  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_PRESENT = 2'd1,
    OUT_GAP     = 2'd2
  } out_state_e;

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage with wrapping read/write pointers and a separately tracked occupancy level.
module noc_fifo_mem
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = NOC_ADDR_W + NOC_DATA_W,
  parameter int unsigned DEPTH = NOC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/noc_link_buffer.sv
// Elastic flit buffer on a mesh link: acks upstream pushes, presents the head flit to the router
// through a registered IDLE/PRESENT/GAP output FSM, and flags acks arriving with nothing presented.
module noc_link_buffer
  import noc_pkg::*;
#(
  parameter int unsigned ADDR_W = NOC_ADDR_W,
  parameter int unsigned DATA_W = NOC_DATA_W,
  parameter int unsigned DEPTH  = NOC_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   to_in_ack,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   from_out_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   proto_err
);

  localparam int unsigned FLIT_W = ADDR_W + DATA_W;

  out_state_e        state_q, state_d;
  logic              ack_q, ack_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              proto_err_q, proto_err_d;
  logic              push, pop;
  logic [FLIT_W-1:0] head;

  // A push is blocked in the cycle its predecessor is being acked, capping upstream at 1 flit / 2 cycles.
  assign push        = in_valid && !full && !ack_q;
  assign pop         = (state_q == OUT_PRESENT) && from_out_ack;
  assign ack_d       = push ? LINK_ACK : LINK_IDLE;
  assign proto_err_d = proto_err_q | (from_out_ack & ~out_valid_q);

  noc_fifo_mem #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_addr, in_data}),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OUT_IDLE;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_IDLE:    if (!empty) state_d = OUT_PRESENT;
      OUT_PRESENT: if (from_out_ack) state_d = OUT_GAP;
      OUT_GAP:     state_d = OUT_IDLE;
      default:     state_d = OUT_IDLE;
    endcase
  end

  // Payload registers only change on an IDLE load, so they hold the last flit through PRESENT and GAP.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      OUT_IDLE: begin
        if (!empty) begin
          out_valid_d = 1'b1;
          out_addr_d  = head[FLIT_W-1 -: ADDR_W];
          out_data_d  = head[DATA_W-1:0];
        end
      end
      OUT_PRESENT: if (from_out_ack) out_valid_d = 1'b0;
      default:     out_valid_d = 1'b0;
    endcase
  end

  assign to_in_ack = ack_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_noc_link_buffer.sv
// Directed bench for noc_link_buffer: a vector table for the single-flit handshake plus
// hand-written sequences for reset, back-pressure, pointer wrap, push/pop overlap and protocol errors.
module tb_noc_link_buffer;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        to_in_ack;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        from_out_ack;
  logic [2:0]  level;
  logic        full;
  logic        empty;
  logic        proto_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  noc_link_buffer #(
    .ADDR_W (5),
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .to_in_ack    (to_in_ack),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .from_out_ack (from_out_ack),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        ack;
    logic        e_ack;
    logic        e_ov;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_level;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ack", 64'(to_in_ack), 64'(0));
    chk("rst_ovalid", 64'(out_valid), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_perr", 64'(proto_err), 64'(0));
    chk("rst_oaddr", 64'(out_addr), 64'(0));
    chk("rst_odata", 64'(out_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic push_flit(input logic [4:0] a, input logic [31:0] d);
    bit done = 1'b0;
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 24 && !done; i++) begin
      tick();
      if (to_in_ack) done = 1'b1;
    end
    in_valid = 1'b0;
    chk("push_acked", 64'(done), 64'(1));
  endtask

  task automatic drain_expect(input logic [4:0] a, input logic [31:0] d, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    chk({name, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({name, "_addr"}, 64'(out_addr), 64'(a));
      chk({name, "_data"}, 64'(out_data), 64'(d));
      from_out_ack = 1'b1;
      tick();
      from_out_ack = 1'b0;
      chk({name, "_bubble"}, 64'(out_valid), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid     = 1'b0;
    in_addr      = '0;
    in_data      = '0;
    from_out_ack = 1'b0;

    tv[0] = '{1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         3'd1, 1'b0, 1'b0};
    tv[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF, 3'd1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF, 3'd1, 1'b0, 1'b0};
    tv[3] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF, 3'd1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 5'd14, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd14, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0};
    tv[6] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd14, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0};

    do_reset();

    // T2: single flit through the table
    for (int i = 0; i < 7; i++) begin
      in_valid     = tv[i].in_valid;
      in_addr      = tv[i].in_addr;
      in_data      = tv[i].in_data;
      from_out_ack = tv[i].ack;
      tick();
      chk($sformatf("t2[%0d].ack", i),   64'(to_in_ack), 64'(tv[i].e_ack));
      chk($sformatf("t2[%0d].ov", i),    64'(out_valid), 64'(tv[i].e_ov));
      chk($sformatf("t2[%0d].addr", i),  64'(out_addr),  64'(tv[i].e_addr));
      chk($sformatf("t2[%0d].data", i),  64'(out_data),  64'(tv[i].e_data));
      chk($sformatf("t2[%0d].level", i), 64'(level),     64'(tv[i].e_level));
      chk($sformatf("t2[%0d].empty", i), 64'(empty),     64'(tv[i].e_empty));
      chk($sformatf("t2[%0d].full", i),  64'(full),      64'(tv[i].e_full));
      chk($sformatf("t2[%0d].perr", i),  64'(proto_err), 64'(0));
    end
    from_out_ack = 1'b0;

    // T3: back-pressure with the router stalled
    do_reset();
    for (int i = 0; i < 4; i++) push_flit(5'(i), 32'hA000_0000 + 32'(i));
    chk("t3_full", 64'(full), 64'(1));
    chk("t3_level4", 64'(level), 64'(4));
    in_addr  = 5'd4;
    in_data  = 32'hA000_0004;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_noack[%0d]", i), 64'(to_in_ack), 64'(0));
    end
    chk("t3_head_valid", 64'(out_valid), 64'(1));
    chk("t3_head_addr", 64'(out_addr), 64'(0));
    chk("t3_head_data", 64'(out_data), 64'(32'hA000_0000));
    from_out_ack = 1'b1;
    tick();
    from_out_ack = 1'b0;
    chk("t3_pop_refuses_push", 64'(to_in_ack), 64'(0));
    chk("t3_level3", 64'(level), 64'(3));
    tick();
    chk("t3_late_ack", 64'(to_in_ack), 64'(1));
    chk("t3_level4b", 64'(level), 64'(4));
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) drain_expect(5'(i), 32'hA000_0000 + 32'(i), $sformatf("t3_out%0d", i));
    tick();
    chk("t3_empty", 64'(empty), 64'(1));

    // T4: continuous push and drain across pointer wrap
    do_reset();
    fork
      for (int i = 0; i < 10; i++) push_flit(5'(i + 3), 32'hC0DE_0000 + 32'(i));
      for (int j = 0; j < 10; j++) drain_expect(5'(j + 3), 32'hC0DE_0000 + 32'(j), $sformatf("t4_out%0d", j));
    join
    tick();
    tick();
    chk("t4_empty", 64'(empty), 64'(1));
    chk("t4_level", 64'(level), 64'(0));
    chk("t4_ovalid", 64'(out_valid), 64'(0));
    chk("t4_perr", 64'(proto_err), 64'(0));

    // T5: simultaneous push and pop at level 2
    do_reset();
    push_flit(5'd20, 32'h1111_0020);
    push_flit(5'd21, 32'h1111_0021);
    tick();
    chk("t5_level2", 64'(level), 64'(2));
    chk("t5_ovalid", 64'(out_valid), 64'(1));
    chk("t5_head", 64'(out_addr), 64'(20));
    in_addr      = 5'd22;
    in_data      = 32'h1111_0022;
    in_valid     = 1'b1;
    from_out_ack = 1'b1;
    tick();
    in_valid     = 1'b0;
    from_out_ack = 1'b0;
    chk("t5_pushed", 64'(to_in_ack), 64'(1));
    chk("t5_level_same", 64'(level), 64'(2));
    chk("t5_popped", 64'(out_valid), 64'(0));
    drain_expect(5'd21, 32'h1111_0021, "t5_outB");
    drain_expect(5'd22, 32'h1111_0022, "t5_outC");
    tick();
    chk("t5_empty", 64'(empty), 64'(1));

    // T6: router ack with nothing presented
    do_reset();
    from_out_ack = 1'b1;
    tick();
    from_out_ack = 1'b0;
    chk("t6_perr_set", 64'(proto_err), 64'(1));
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_empty", 64'(empty), 64'(1));
    chk("t6_ovalid", 64'(out_valid), 64'(0));
    tick();
    tick();
    chk("t6_perr_sticky", 64'(proto_err), 64'(1));
    push_flit(5'd7, 32'h0000_0077);
    drain_expect(5'd7, 32'h0000_0077, "t6_after");
    chk("t6_perr_still", 64'(proto_err), 64'(1));

    // T1: reset mid-stream with three flits stored and an ack in flight
    do_reset();
    for (int i = 0; i < 3; i++) push_flit(5'(i + 10), 32'hBEEF_0000 + 32'(i));
    chk("t1_level3", 64'(level), 64'(3));
    chk("t1_ack_live", 64'(to_in_ack), 64'(1));
    do_reset();
    push_flit(5'd9, 32'h0000_0099);
    drain_expect(5'd9, 32'h0000_0099, "t1_fresh");
    tick();
    chk("t1_empty", 64'(empty), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
